// File: rtl/idct_ifft_sched.sv
// Frame scheduler that shares one streaming IDCT/IFFT core between two requesters:
// round-robin grant per frame, sink sop/eop generation and owner tagging of output frames.
module idct_ifft_sched #(
    parameter int DW        = 24,
    parameter int PTS_W     = 12,
    parameter int TAG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rq0_valid,
    output logic             rq0_ready,
    input  logic             rq0_sop,
    input  logic [DW-1:0]    rq0_real,
    input  logic [DW-1:0]    rq0_imag,
    input  logic [PTS_W-1:0] rq0_pts,
    input  logic             rq0_inv,
    input  logic             rq1_valid,
    output logic             rq1_ready,
    input  logic             rq1_sop,
    input  logic [DW-1:0]    rq1_real,
    input  logic [DW-1:0]    rq1_imag,
    input  logic [PTS_W-1:0] rq1_pts,
    input  logic             rq1_inv,
    output logic             fft_sink_valid,
    output logic             fft_sink_sop,
    output logic             fft_sink_eop,
    input  logic             fft_sink_ready,
    output logic [DW-1:0]    fft_sink_real,
    output logic [DW-1:0]    fft_sink_imag,
    output logic [1:0]       fft_sink_error,
    output logic [PTS_W-1:0] fft_fftpts,
    output logic             fft_inverse,
    input  logic             fft_source_valid,
    input  logic             fft_source_ready,
    input  logic             fft_source_sop,
    input  logic             fft_source_eop,
    input  logic [1:0]       fft_source_error,
    output logic             out_tag,
    output logic             out_tag_valid,
    output logic             cfg_err,
    output logic             frm_err,
    output logic             tag_err,
    output logic             src_err
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [PTS_W-1:0] PTS_ONE = PTS_W'(1);
    localparam logic [PTS_W-1:0] PTS_MIN = PTS_W'(8);
    localparam logic [PTS_W-1:0] PTS_MAX = PTS_W'(2048);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(TAG_DEPTH);

    logic [1:0]           state_q, state_d;
    logic                 rr_q, rr_d;
    logic                 gnt_q, gnt_d;
    logic                 armed_q, armed_d;
    logic                 inv_q, inv_d;
    logic [PTS_W-1:0]     pts_q, pts_d;
    logic [PTS_W-1:0]     cnt_q, cnt_d;
    logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        tag_cnt_q, tag_cnt_d;
    logic                 cfg_err_q, cfg_err_d, frm_err_q, frm_err_d;
    logic                 tag_err_q, tag_err_d, src_err_q, src_err_d;

    logic             elig0, elig1, sel_id, sel_inv, pts_legal, grant, push, pop;
    logic [PTS_W-1:0] sel_pts;
    logic             tag_full, tag_empty, g_valid, g_sop, g_ready, xfer, last_beat;

    assign elig0     = rq0_valid && rq0_sop;
    assign elig1     = rq1_valid && rq1_sop;
    assign sel_id    = (elig0 && elig1) ? rr_q : elig1;
    assign sel_pts   = sel_id ? rq1_pts : rq0_pts;
    assign sel_inv   = sel_id ? rq1_inv : rq0_inv;
    assign pts_legal = (sel_pts >= PTS_MIN) && (sel_pts <= PTS_MAX)
                       && ((sel_pts & (sel_pts - PTS_ONE)) == '0);
    assign tag_full  = (tag_cnt_q == CNT_FULL);
    assign tag_empty = (tag_cnt_q == '0);
    assign grant     = (state_q == S_IDLE) && (elig0 || elig1) && !tag_full;
    assign push      = grant && pts_legal;
    assign pop       = fft_source_valid && fft_source_ready && fft_source_eop && !tag_empty;
    assign g_valid   = gnt_q ? rq1_valid : rq0_valid;
    assign g_sop     = gnt_q ? rq1_sop : rq0_sop;
    assign xfer      = fft_sink_valid && fft_sink_ready;
    assign last_beat = (cnt_q == pts_q - PTS_ONE);

    // In DRAIN the offending sop beat is swallowed first; only a later sop ends the drain.
    always_comb begin
        fft_sink_valid = 1'b0;
        fft_sink_sop   = 1'b0;
        fft_sink_eop   = 1'b0;
        fft_sink_real  = '0;
        fft_sink_imag  = '0;
        g_ready        = 1'b0;
        case (state_q)
            S_STREAM: begin
                fft_sink_valid = g_valid;
                fft_sink_sop   = g_valid && (cnt_q == '0);
                fft_sink_eop   = g_valid && last_beat;
                fft_sink_real  = gnt_q ? rq1_real : rq0_real;
                fft_sink_imag  = gnt_q ? rq1_imag : rq0_imag;
                g_ready        = fft_sink_ready;
            end
            S_DRAIN: g_ready = !(armed_q && g_valid && g_sop);
            default: g_ready = 1'b0;
        endcase
        rq0_ready = g_ready && !gnt_q;
        rq1_ready = g_ready && gnt_q;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        armed_d   = armed_q;
        pts_d     = pts_q;
        inv_d     = inv_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        frm_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    gnt_d   = sel_id;
                    pts_d   = sel_pts;
                    inv_d   = sel_inv;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                    if (pts_legal) begin
                        rr_d    = !sel_id;
                        state_d = S_STREAM;
                    end else begin
                        rr_d      = sel_id;
                        cfg_err_d = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    cnt_d     = cnt_q + PTS_ONE;
                    frm_err_d = g_sop && (cnt_q != '0);
                    if (last_beat) state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (armed_q && g_valid && g_sop) state_d = S_IDLE;
                else if (g_valid)                armed_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tag_cnt_d = tag_cnt_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = sel_id;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      tag_cnt_d = tag_cnt_q + CNT_ONE;
        else if (pop && !push) tag_cnt_d = tag_cnt_q - CNT_ONE;
        tag_err_d = fft_source_valid && fft_source_ready && fft_source_sop && tag_empty;
        src_err_d = fft_source_valid && (fft_source_error != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rr_q      <= 1'b0;
            gnt_q     <= 1'b0;
            armed_q   <= 1'b0;
            pts_q     <= '0;
            inv_q     <= 1'b0;
            cnt_q     <= '0;
            tag_mem_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_cnt_q <= '0;
            cfg_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            tag_err_q <= 1'b0;
            src_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            armed_q   <= armed_d;
            pts_q     <= pts_d;
            inv_q     <= inv_d;
            cnt_q     <= cnt_d;
            tag_mem_q <= tag_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tag_cnt_q <= tag_cnt_d;
            cfg_err_q <= cfg_err_d;
            frm_err_q <= frm_err_d;
            tag_err_q <= tag_err_d;
            src_err_q <= src_err_d;
        end
    end

    assign fft_sink_error = 2'b00;
    assign fft_fftpts     = pts_q;
    assign fft_inverse    = inv_q;
    assign out_tag        = tag_mem_q[rd_ptr_q];
    assign out_tag_valid  = !tag_empty;
    assign cfg_err        = cfg_err_q;
    assign frm_err        = frm_err_q;
    assign tag_err        = tag_err_q;
    assign src_err        = src_err_q;

endmodule

// File: tb/tb_idct_ifft_sched.sv
// Scoreboard bench for idct_ifft_sched: requester drivers feed queued frames, expected
// sink beats and tags are queued at stimulus time and compared as the DUT emits them.
module tb_idct_ifft_sched;

    localparam int DW    = 24;
    localparam int PTS_W = 12;

    typedef struct {
        logic [DW-1:0]    re;
        logic [DW-1:0]    im;
        logic             sop;
        logic [PTS_W-1:0] pts;
        logic             inv;
    } stim_t;

    typedef struct {
        logic [DW-1:0]    re;
        logic [DW-1:0]    im;
        logic             sop;
        logic             eop;
        logic [PTS_W-1:0] pts;
        logic             inv;
    } exp_t;

    logic clk, reset_n;
    logic rq0_valid, rq0_ready, rq0_sop, rq0_inv;
    logic rq1_valid, rq1_ready, rq1_sop, rq1_inv;
    logic [DW-1:0] rq0_real, rq0_imag, rq1_real, rq1_imag;
    logic [PTS_W-1:0] rq0_pts, rq1_pts;
    logic fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_ready;
    logic [DW-1:0] fft_sink_real, fft_sink_imag;
    logic [1:0] fft_sink_error;
    logic [PTS_W-1:0] fft_fftpts;
    logic fft_inverse;
    logic fft_source_valid, fft_source_ready, fft_source_sop, fft_source_eop;
    logic [1:0] fft_source_error;
    logic out_tag, out_tag_valid, cfg_err, frm_err, tag_err, src_err;

    stim_t s0_q[$];
    stim_t s1_q[$];
    exp_t  exp_q[$];
    bit    exp_tag_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int xfer_cnt = 0;
    int cfg_cnt  = 0;
    int frm_cnt  = 0;
    int last_eop_cyc = 0;
    bit mon_en = 1'b1;
    bit gap_chk = 1'b0;
    bit eop_seen = 1'b0;
    bit gap0 = 1'b0;
    bit gap1 = 1'b0;
    bit toggle_ready = 1'b0;

    idct_ifft_sched #(.DW(DW), .PTS_W(PTS_W), .TAG_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_sop(rq0_sop),
        .rq0_real(rq0_real), .rq0_imag(rq0_imag), .rq0_pts(rq0_pts), .rq0_inv(rq0_inv),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_sop(rq1_sop),
        .rq1_real(rq1_real), .rq1_imag(rq1_imag), .rq1_pts(rq1_pts), .rq1_inv(rq1_inv),
        .fft_sink_valid(fft_sink_valid), .fft_sink_sop(fft_sink_sop),
        .fft_sink_eop(fft_sink_eop), .fft_sink_ready(fft_sink_ready),
        .fft_sink_real(fft_sink_real), .fft_sink_imag(fft_sink_imag),
        .fft_sink_error(fft_sink_error), .fft_fftpts(fft_fftpts), .fft_inverse(fft_inverse),
        .fft_source_valid(fft_source_valid), .fft_source_ready(fft_source_ready),
        .fft_source_sop(fft_source_sop), .fft_source_eop(fft_source_eop),
        .fft_source_error(fft_source_error),
        .out_tag(out_tag), .out_tag_valid(out_tag_valid),
        .cfg_err(cfg_err), .frm_err(frm_err), .tag_err(tag_err), .src_err(src_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester 0 driver: presents the queue head, retires it once accepted.
    initial begin
        bit acc;
        rq0_valid = 1'b0; rq0_sop = 1'b0; rq0_real = '0; rq0_imag = '0; rq0_pts = '0; rq0_inv = 1'b0;
        forever begin
            @(negedge clk);
            acc = rq0_valid && rq0_ready;
            @(posedge clk); #1;
            if (acc && s0_q.size() > 0) s0_q.delete(0);
            if (s0_q.size() > 0 && !(gap0 && $urandom_range(0, 2) == 0)) begin
                rq0_valid = 1'b1; rq0_sop = s0_q[0].sop; rq0_real = s0_q[0].re;
                rq0_imag = s0_q[0].im; rq0_pts = s0_q[0].pts; rq0_inv = s0_q[0].inv;
            end else begin
                rq0_valid = 1'b0;
            end
        end
    end

    // Requester 1 driver.
    initial begin
        bit acc;
        rq1_valid = 1'b0; rq1_sop = 1'b0; rq1_real = '0; rq1_imag = '0; rq1_pts = '0; rq1_inv = 1'b0;
        forever begin
            @(negedge clk);
            acc = rq1_valid && rq1_ready;
            @(posedge clk); #1;
            if (acc && s1_q.size() > 0) s1_q.delete(0);
            if (s1_q.size() > 0 && !(gap1 && $urandom_range(0, 2) == 0)) begin
                rq1_valid = 1'b1; rq1_sop = s1_q[0].sop; rq1_real = s1_q[0].re;
                rq1_imag = s1_q[0].im; rq1_pts = s1_q[0].pts; rq1_inv = s1_q[0].inv;
            end else begin
                rq1_valid = 1'b0;
            end
        end
    end

    initial begin
        fft_sink_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            fft_sink_ready = toggle_ready ? ~fft_sink_ready : 1'b1;
        end
    end

    // Sink monitor: every accepted beat must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && cfg_err) cfg_cnt++;
            if (reset_n && frm_err) frm_cnt++;
            if (mon_en && reset_n && fft_sink_valid && fft_sink_ready) begin
                xfer_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_sink_xfer: got beat re=%h at cycle %0d, required none",
                             fft_sink_real, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({fft_sink_real, fft_sink_imag, fft_sink_sop, fft_sink_eop, fft_fftpts, fft_inverse}
                        !== {e.re, e.im, e.sop, e.eop, e.pts, e.inv}) begin
                        n_fail++;
                        $display("[TB] FAIL sink_beat: got re=%h im=%h sop=%b eop=%b pts=%0d inv=%b, required re=%h im=%h sop=%b eop=%b pts=%0d inv=%b",
                                 fft_sink_real, fft_sink_imag, fft_sink_sop, fft_sink_eop, fft_fftpts,
                                 fft_inverse, e.re, e.im, e.sop, e.eop, e.pts, e.inv);
                    end
                    if (gap_chk && e.sop && eop_seen) begin
                        n_checks++;
                        if (cyc - last_eop_cyc !== 2) begin
                            n_fail++;
                            $display("[TB] FAIL frame_gap: got %0d cycles eop->sop, required 2",
                                     cyc - last_eop_cyc);
                        end
                    end
                    if (e.eop) begin
                        eop_seen     = 1'b1;
                        last_eop_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic push_frame(input int rq, input int n, input int pts, input bit inv,
                              input bit expect_out, input int extra_sop);
        stim_t s;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            s.re  = DW'($urandom);
            s.im  = DW'($urandom);
            s.sop = (i == 0) || (i == extra_sop);
            s.pts = PTS_W'(pts);
            s.inv = inv;
            if (rq == 0) s0_q.push_back(s);
            else         s1_q.push_back(s);
            if (expect_out) begin
                e.re = s.re; e.im = s.im; e.sop = (i == 0); e.eop = (i == n - 1);
                e.pts = PTS_W'(pts); e.inv = inv;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit to);
        to = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && s0_q.size() == 0 && s1_q.size() == 0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic src_pulse(input bit sop, input bit eop, input logic [1:0] err);
        @(posedge clk); #1;
        fft_source_valid = 1'b1; fft_source_ready = 1'b1;
        fft_source_sop = sop; fft_source_eop = eop; fft_source_error = err;
        @(posedge clk); #1;
        fft_source_valid = 1'b0; fft_source_ready = 1'b0;
        fft_source_sop = 1'b0; fft_source_eop = 1'b0; fft_source_error = 2'b00;
    endtask

    task automatic reset_assert();
        @(posedge clk); #1;
        reset_n = 1'b0;
        s0_q.delete(); s1_q.delete(); exp_q.delete(); exp_tag_q.delete();
        toggle_ready = 1'b0; gap0 = 1'b0; gap1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset_assert();
        n_checks++;
        if ({fft_sink_valid, fft_sink_sop, fft_sink_eop, rq0_ready, rq1_ready} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake: got %b, required 00000",
                     {fft_sink_valid, fft_sink_sop, fft_sink_eop, rq0_ready, rq1_ready});
        end
        n_checks++;
        if ({fft_fftpts, fft_inverse} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_cfg: got pts=%0d inv=%b, required 0 0", fft_fftpts, fft_inverse);
        end
        n_checks++;
        if ({out_tag, out_tag_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_tag: got %b, required 00", {out_tag, out_tag_valid});
        end
        n_checks++;
        if ({cfg_err, frm_err, tag_err, src_err, fft_sink_error} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_errors: got %b, required 000000",
                     {cfg_err, frm_err, tag_err, src_err, fft_sink_error});
        end
        reset_release();
    endtask

    task automatic test_single();
        bit to;
        $display("[TB] test_single");
        xfer_cnt = 0;
        push_frame(0, 64, 64, 1'b1, 1'b1, -1);
        wait_done(2000, to);
        n_checks++;
        if (to) begin n_fail++; $display("[TB] FAIL single_timeout: got timeout, required completion"); end
        @(negedge clk);
        n_checks++;
        if (xfer_cnt !== 64) begin n_fail++; $display("[TB] FAIL single_xfers: got %0d, required 64", xfer_cnt); end
        n_checks++;
        if ({out_tag_valid, out_tag} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL single_tag: got valid=%b tag=%b, required 1 0", out_tag_valid, out_tag);
        end
        n_checks++;
        if ({fft_fftpts, fft_inverse} !== {PTS_W'(64), 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL single_cfg_hold: got pts=%0d inv=%b, required 64 1", fft_fftpts, fft_inverse);
        end
        src_pulse(1'b0, 1'b1, 2'b00);
        @(negedge clk);
        n_checks++;
        if (out_tag_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_tag_pop: got valid=%b, required 0", out_tag_valid);
        end
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        mon_en = 1'b0;
        push_frame(1, 64, 64, 1'b0, 1'b0, -1);
        repeat (20) @(posedge clk);
        reset_assert();
        n_checks++;
        if ({fft_sink_valid, rq1_ready, fft_fftpts, out_tag_valid} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got valid=%b rdy=%b pts=%0d tagv=%b, required all 0",
                     fft_sink_valid, rq1_ready, fft_fftpts, out_tag_valid);
        end
        reset_release();
        mon_en = 1'b1;
    endtask

    task automatic test_contention();
        bit to;
        $display("[TB] test_contention");
        eop_seen = 1'b0;
        gap_chk  = 1'b1;
        for (int f = 0; f < 4; f++) begin
            push_frame(0, 16, 16, 1'b0, 1'b1, -1);
            exp_tag_q.push_back(1'b0);
            push_frame(1, 16, 16, 1'b1, 1'b1, -1);
            exp_tag_q.push_back(1'b1);
        end
        fork
            wait_done(3000, to);
            begin
                for (int i = 0; i < 8; i++) begin
                    bit ptmo;
                    bit et;
                    ptmo = 1'b1;
                    for (int k = 0; k < 3000; k++) begin
                        @(negedge clk);
                        if (out_tag_valid) begin ptmo = 1'b0; break; end
                    end
                    n_checks++;
                    if (ptmo) begin
                        n_fail++;
                        $display("[TB] FAIL contention_tag_wait: got no tag, required tag %0d", i);
                    end else begin
                        et = exp_tag_q.pop_front();
                        if (out_tag !== et) begin
                            n_fail++;
                            $display("[TB] FAIL contention_tag: got %b, required %b", out_tag, et);
                        end
                    end
                    src_pulse(1'b0, 1'b1, 2'b00);
                end
            end
        join
        gap_chk = 1'b0;
        n_checks++;
        if (to) begin n_fail++; $display("[TB] FAIL contention_timeout: got timeout, required completion"); end
    endtask

    task automatic test_backpressure();
        bit to;
        $display("[TB] test_backpressure");
        xfer_cnt = 0;
        toggle_ready = 1'b1;
        gap1 = 1'b1;
        push_frame(1, 32, 32, 1'b0, 1'b1, -1);
        wait_done(2000, to);
        toggle_ready = 1'b0;
        gap1 = 1'b0;
        n_checks++;
        if (to) begin n_fail++; $display("[TB] FAIL bp_timeout: got timeout, required completion"); end
        @(negedge clk);
        n_checks++;
        if (xfer_cnt !== 32) begin n_fail++; $display("[TB] FAIL bp_xfers: got %0d, required 32", xfer_cnt); end
        n_checks++;
        if ({out_tag_valid, out_tag} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL bp_tag: got valid=%b tag=%b, required 1 1", out_tag_valid, out_tag);
        end
        src_pulse(1'b0, 1'b1, 2'b00);
    endtask

    task automatic test_illegal();
        bit to;
        $display("[TB] test_illegal");
        xfer_cnt = 0;
        cfg_cnt  = 0;
        push_frame(1, 10, 100, 1'b0, 1'b0, -1);
        push_frame(1, 128, 128, 1'b1, 1'b1, -1);
        wait_done(3000, to);
        n_checks++;
        if (to) begin n_fail++; $display("[TB] FAIL illegal_timeout: got timeout, required completion"); end
        @(negedge clk);
        n_checks++;
        if (cfg_cnt !== 1) begin n_fail++; $display("[TB] FAIL illegal_cfg_err: got %0d pulses, required 1", cfg_cnt); end
        n_checks++;
        if (xfer_cnt !== 128) begin n_fail++; $display("[TB] FAIL illegal_xfers: got %0d, required 128", xfer_cnt); end
        n_checks++;
        if ({out_tag_valid, out_tag} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL illegal_tag: got valid=%b tag=%b, required 1 1", out_tag_valid, out_tag);
        end
        src_pulse(1'b0, 1'b1, 2'b00);
        @(negedge clk);
        n_checks++;
        if (out_tag_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL illegal_no_extra_tag: got valid=%b, required 0", out_tag_valid);
        end
    endtask

    task automatic test_tag_full();
        bit to;
        bit et;
        $display("[TB] test_tag_full");
        reset_assert();
        reset_release();
        xfer_cnt = 0;
        for (int f = 0; f < 5; f++) begin
            push_frame(f % 2, 8, 8, 1'b0, 1'b1, -1);
            exp_tag_q.push_back(1'(f % 2));
        end
        repeat (80) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (xfer_cnt !== 32) begin n_fail++; $display("[TB] FAIL full_blocks: got %0d xfers, required 32", xfer_cnt); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            et = exp_tag_q.pop_front();
            n_checks++;
            if ({out_tag_valid, out_tag} !== {1'b1, et}) begin
                n_fail++;
                $display("[TB] FAIL full_tag_order: got valid=%b tag=%b, required 1 %b", out_tag_valid, out_tag, et);
            end
            src_pulse(1'b0, 1'b1, 2'b00);
            if (i == 0) begin
                wait_done(500, to);
                @(negedge clk);
                n_checks++;
                if (to || xfer_cnt !== 40) begin
                    n_fail++;
                    $display("[TB] FAIL full_release: got %0d xfers timeout=%b, required 40 0", xfer_cnt, to);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_tag_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_drained: got valid=%b, required 0", out_tag_valid);
        end
    endtask

    task automatic test_errors();
        bit to;
        $display("[TB] test_errors");
        src_pulse(1'b1, 1'b1, 2'b00);
        @(negedge clk);
        n_checks++;
        if ({tag_err, out_tag_valid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL tag_err: got tag_err=%b tagv=%b, required 1 0", tag_err, out_tag_valid);
        end
        @(negedge clk);
        n_checks++;
        if (tag_err !== 1'b0) begin n_fail++; $display("[TB] FAIL tag_err_pulse: got %b, required 0", tag_err); end
        src_pulse(1'b0, 1'b0, 2'b01);
        @(negedge clk);
        n_checks++;
        if ({src_err, tag_err} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL src_err: got src_err=%b tag_err=%b, required 1 0", src_err, tag_err);
        end
        @(negedge clk);
        n_checks++;
        if (src_err !== 1'b0) begin n_fail++; $display("[TB] FAIL src_err_pulse: got %b, required 0", src_err); end
        frm_cnt = 0;
        push_frame(0, 8, 8, 1'b0, 1'b1, 5);
        wait_done(500, to);
        @(negedge clk);
        n_checks++;
        if (to || frm_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL frm_err: got %0d pulses timeout=%b, required 1 0", frm_cnt, to);
        end
        src_pulse(1'b0, 1'b1, 2'b00);
    endtask

    initial begin
        reset_n = 1'b0;
        fft_source_valid = 1'b0; fft_source_ready = 1'b0;
        fft_source_sop = 1'b0; fft_source_eop = 1'b0; fft_source_error = 2'b00;
        test_reset();
        test_single();
        test_reset_mid();
        test_contention();
        test_backpressure();
        test_illegal();
        test_tag_full();
        test_errors();
        repeat (5) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL leftover_expected: got %0d beats outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
